// File: rtl/demux_router_pkg.sv
// Common constants and helpers for demux_router and demux_slot.
`include "demux_defs.vh"
package demux_router_pkg;
  localparam int DEF_WIDTH = `DEMUX_DEF_WIDTH;
  localparam int MAX_N_OUT = `DEMUX_MAX_N_OUT;
  localparam int CNT_W     = `DEMUX_CNT_W;

  // Wrapping statistics counter step; clear wins over increment.
  function automatic logic [CNT_W-1:0] cnt_next(input logic clr, input logic inc,
                                                 input logic [CNT_W-1:0] cnt);
    if (clr) return '0;
    if (inc) return cnt + 1'b1;
    return cnt;
  endfunction
endpackage

// File: rtl/demux_defs.vh
// Shared build-time defaults for the demux_router slice.
`ifndef DEMUX_DEFS_VH
`define DEMUX_DEFS_VH
`define DEMUX_DEF_WIDTH 32
`define DEMUX_MAX_N_OUT 8
`define DEMUX_CNT_W 16
`endif

// File: rtl/demux_slot.sv
// One-deep output register for a single destination of demux_router.
// DEMUX_ROUTER_STATS_EN adds a per-slot drain counter.
module demux_slot
  import demux_router_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
`ifdef DEMUX_ROUTER_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             drain;

  assign drain = valid_q & ready;

  // A load in the drain cycle keeps the slot valid: one word per cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

`ifdef DEMUX_ROUTER_STATS_EN
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  always_comb xfer_cnt_d = cnt_next(stats_clr, drain, xfer_cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_cnt_q <= '0;
    else        xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt = xfer_cnt_q;
`endif
endmodule

// File: rtl/demux_router.sv
// Routes one valid/ready word stream to N_OUT one-deep output slots by in_sel.
// DEMUX_ROUTER_STATS_EN adds drain/drop counters and a stats_clr input.
module demux_router
  import demux_router_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_OUT = 2,
  parameter int SEL_W = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic                   drop_err
`ifdef DEMUX_ROUTER_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [N_OUT*CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0]       drop_cnt
`endif
);
  localparam int NSEL = 1 << SEL_W;

  // Handshake: a word moves when in_valid & in_ready; a slot drains when
  // out_valid[k] & out_ready[k]. in_ready never looks at in_valid.
  logic [NSEL-1:0]  slot_free;
  logic [N_OUT-1:0] load;
  logic             sel_legal;
  logic             accept;
  logic             drop_err_q, drop_err_d;

  // Unused select codes read as free so illegal words are always taken.
  always_comb begin
    slot_free = '1;
    for (int k = 0; k < N_OUT; k++) slot_free[k] = ~out_valid[k] | out_ready[k];
  end

  assign sel_legal = ({1'b0, in_sel} < (SEL_W+1)'(N_OUT));
  assign in_ready  = slot_free[in_sel];
  assign accept    = in_valid & in_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < N_OUT; k++) load[k] = accept & sel_legal & (in_sel == SEL_W'(k));
    drop_err_d = accept & ~sel_legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_err_q <= 1'b0;
    else        drop_err_q <= drop_err_d;
  end

  assign drop_err = drop_err_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (in_data),
      .ready     (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (out_data[k*WIDTH +: WIDTH])
`ifdef DEMUX_ROUTER_STATS_EN
      ,
      .stats_clr (stats_clr),
      .xfer_cnt  (xfer_cnt[k*CNT_W +: CNT_W])
`endif
    );
  end

`ifdef DEMUX_ROUTER_STATS_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Counts alongside the pulse so drop_cnt rises with drop_err.
  always_comb drop_cnt_d = cnt_next(stats_clr, drop_err_d, drop_cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_demux_router.sv
// Randomized and directed bench for demux_router with three destinations,
// checked against a per-destination queue model.
module tb_demux_router;
  localparam int W = 32;
  localparam int N = 3;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [S-1:0]   in_sel;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic [N*W-1:0] out_data;
  logic           drop_err;
`ifdef DEMUX_ROUTER_STATS_EN
  logic           stats_clr;
  logic [N*16-1:0] xfer_cnt;
  logic [15:0]    drop_cnt;
`endif

  always #5 clk = ~clk;

  demux_router #(.WIDTH(W), .N_OUT(N), .SEL_W(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_err  (drop_err)
`ifdef DEMUX_ROUTER_STATS_EN
    ,
    .stats_clr (stats_clr),
    .xfer_cnt  (xfer_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: each destination is a queue of words not yet consumed.
  logic [W-1:0] exp_q[N][$];
  logic [W-1:0] mlast[N];
  logic [15:0]  mx[N];
  logic [15:0]  md;
  bit           exp_drop;
  bit           last_acc;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      exp_q[k].delete();
      mlast[k] = '0;
      mx[k]    = '0;
    end
    md       = '0;
    exp_drop = 1'b0;
    last_acc = 1'b0;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next one.
  task automatic step();
    logic [N-1:0] exp_v;
    logic [N-1:0] drains;
    bit exp_rdy, legal, acc;
    int s;
    #1;
    for (int k = 0; k < N; k++) exp_v[k] = (exp_q[k].size() != 0);
    check_eq("out_valid", 64'(out_valid), 64'(exp_v));
    for (int k = 0; k < N; k++)
      check_eq($sformatf("out_data%0d", k), 64'(out_data[k*W +: W]),
               64'(exp_v[k] ? exp_q[k][0] : mlast[k]));
    check_eq("drop_err", 64'(drop_err), 64'(exp_drop));
`ifdef DEMUX_ROUTER_STATS_EN
    for (int k = 0; k < N; k++)
      check_eq($sformatf("xfer_cnt%0d", k), 64'(xfer_cnt[k*16 +: 16]), 64'(mx[k]));
    check_eq("drop_cnt", 64'(drop_cnt), 64'(md));
`endif
    s       = int'(in_sel);
    legal   = (s < N);
    exp_rdy = !legal || (exp_q[s].size() == 0) || out_ready[s];
    if (!$isunknown(in_sel)) check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc    = in_valid && exp_rdy;
    drains = exp_v & out_ready;
    @(posedge clk);
    for (int k = 0; k < N; k++)
      if (drains[k]) begin
        mlast[k] = exp_q[k].pop_front();
        mx[k]    = mx[k] + 16'd1;
      end
    if (acc && legal) exp_q[s].push_back(in_data);
    exp_drop = acc && !legal;
    if (exp_drop) md = md + 16'd1;
`ifdef DEMUX_ROUTER_STATS_EN
    if (stats_clr) begin
      for (int k = 0; k < N; k++) mx[k] = '0;
      md = '0;
    end
`endif
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic send(input int sel, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_sel   = sel[S-1:0];
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;
`ifdef DEMUX_ROUTER_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;

    // First word lands in slot 0 one cycle later.
    send(0, 32'h12345678);
    check_eq("first_valid", 64'(out_valid), 64'(3'b001));
    check_eq("first_data", 64'(out_data[31:0]), 64'(32'h12345678));

    // Full-throughput alternation between two ready destinations.
    out_ready = 3'b011;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sel   = S'(i % 2);
      in_data  = (i % 2) ? 32'h11112222 : 32'h87654321;
      #1;
      check_eq("no_bubble", 64'(in_ready), 64'(1'b1));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 3'b111;
    step();
    step();

    // Slot 1 stalls; the pending word waits and then appears.
    out_ready = 3'b001;
    send(1, 32'hAAAA0001);
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("stall_ready", 64'(in_ready), 64'(1'b0));
      step();
    end
    check_eq("stall_hold", 64'(out_data[63:32]), 64'(32'hAAAA0001));
    out_ready = 3'b011;
    step();
    in_valid  = 1'b0;
    out_ready = 3'b000;
    check_eq("release_data", 64'(out_data[63:32]), 64'(32'hDEADBEEF));
    check_eq("release_valid", 64'(out_valid[1]), 64'(1'b1));
    step();

    // Illegal select: accepted, dropped, one-cycle pulse.
    send(3, 32'hBAD0BAD0);
    check_eq("drop_pulse", 64'(drop_err), 64'(1'b1));
    step();
    check_eq("drop_end", 64'(drop_err), 64'(1'b0));

    // Unknown select with no valid word leaves state untouched.
    in_sel = 'x;
    step();
    step();
    in_sel = '0;

    // Asynchronous reset empties slots before the next clock edge.
    send(0, 32'hCAFEF00D);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset", 64'(out_valid), 64'(3'b000));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Randomized traffic; a stalled word is held until accepted.
    for (int i = 0; i < 600; i++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = S'($urandom_range(0, 3));
        in_data  = $urandom;
      end
      out_ready = N'($urandom_range(0, 7));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 3'b111;
    step();
    step();

`ifdef DEMUX_ROUTER_STATS_EN
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    for (int i = 0; i < 70000 && mx[0] != 16'hFFFF; i++) begin
      in_data = $urandom;
      step();
    end
    check_eq("xfer_ffff", 64'(xfer_cnt[15:0]), 64'(16'hFFFF));
    step();
    check_eq("xfer_wrap", 64'(xfer_cnt[15:0]), 64'(16'h0000));
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    check_eq("clr_priority", 64'(xfer_cnt[15:0]), 64'(16'h0000));
    in_valid = 1'b0;
    step();
    send(3, 32'h0BADF00D);
    check_eq("drop_cnt_one", 64'(drop_cnt), 64'(16'd1));
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
